// File: rtl/oc8051_ram_rmw_ctrl_pkg.sv
// oc8051_ram_rmw_ctrl_pkg: op/state encodings, bit-region base and capture record
package oc8051_ram_rmw_ctrl_pkg;

    localparam logic [7:0] BIT_BASE = 8'h20;

    localparam logic [2:0] OP_RD   = 3'd0;
    localparam logic [2:0] OP_WR   = 3'd1;
    localparam logic [2:0] OP_BRD  = 3'd2;
    localparam logic [2:0] OP_BSET = 3'd3;
    localparam logic [2:0] OP_BCLR = 3'd4;
    localparam logic [2:0] OP_BCPL = 3'd5;
    localparam logic [2:0] OP_BMOV = 3'd6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_MODIFY = 2'd3;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] addr;
        logic [2:0] idx;
        logic [7:0] data;
        logic       bitv;
    } req_t;

    function automatic logic is_bit_op(input logic [2:0] op);
        return op >= OP_BRD && op <= OP_BMOV;
    endfunction

    function automatic logic is_rmw_op(input logic [2:0] op);
        return op >= OP_BSET && op <= OP_BMOV;
    endfunction

    function automatic logic is_byte_rd(input logic [2:0] op);
        return op == OP_RD || op == 3'd7;
    endfunction

endpackage

// File: rtl/oc8051_ram_rmw_ctrl_if.sv
// oc8051_ram_rmw_ctrl_if: core request/response and internal-RAM port bundle
interface oc8051_ram_rmw_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_bit;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_bit;
    logic [7:0] ram_rd_addr;
    logic       ram_rd_en;
    logic [7:0] ram_rd_data;
    logic [7:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic       ram_wr;
    logic       ram_wr_en;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_bit, ram_rd_data,
        output req_ready, rsp_valid, rsp_data, rsp_bit,
        output ram_rd_addr, ram_rd_en, ram_wr_addr, ram_wr_data, ram_wr, ram_wr_en
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, req_bit, ram_rd_data,
        input  req_ready, rsp_valid, rsp_data, rsp_bit,
        input  ram_rd_addr, ram_rd_en, ram_wr_addr, ram_wr_data, ram_wr, ram_wr_en
    );
endinterface

// File: rtl/oc8051_ram_rmw_ctrl_bit_mod.sv
// oc8051_bit_mod: combinational bit modify of one RAM byte, returns new byte and pre-modify bit
module oc8051_bit_mod
    import oc8051_ram_rmw_ctrl_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic [2:0] i_idx,
    input  logic [2:0] i_op,
    input  logic       i_bit,
    output logic [7:0] o_byte,
    output logic       o_old
);
    logic [7:0] w_mask;
    logic [7:0] w_set;
    logic [7:0] w_clr;

    always_comb begin
        w_mask = 8'd1 << i_idx;
        w_set  = i_byte | w_mask;
        w_clr  = i_byte & ~w_mask;
        o_old  = i_byte[i_idx];
        o_byte = i_op == OP_BSET ? w_set :
                 i_op == OP_BCLR ? w_clr :
                 i_op == OP_BCPL ? i_byte ^ w_mask :
                 i_op == OP_BMOV ? (i_bit ? w_set : w_clr) : i_byte;
    end
endmodule

// File: rtl/oc8051_ram_rmw_ctrl.sv
// oc8051_ram_rmw_ctrl: byte/bit request sequencer with 3-state read-modify-write in front of the internal RAM
module oc8051_ram_rmw_ctrl
    import oc8051_ram_rmw_ctrl_pkg::*;
(
    input logic                      clk,
    input logic                      rst,
    oc8051_ram_rmw_ctrl_if.slave     io_bus
);
    logic [1:0] r_state;
    req_t       r_req;
    logic       w_read;
    logic       w_write;
    logic       w_modify;
    logic       w_wr;
    logic [7:0] w_new;
    logic       w_old;
    logic [7:0] w_cap_addr;

    // bit address wraps inside the 16-byte bit region
    assign w_cap_addr = is_bit_op(io_bus.req_op) ? BIT_BASE + {4'd0, io_bus.req_addr[6:3]} : io_bus.req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (io_bus.req_valid) begin
                    r_state <= io_bus.req_op == OP_WR ? S_WRITE : S_READ;
                    r_req   <= '{op: io_bus.req_op, addr: w_cap_addr, idx: io_bus.req_addr[2:0],
                                 data: io_bus.req_data, bitv: io_bus.req_bit};
                end
                S_READ:  r_state <= S_MODIFY;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    oc8051_bit_mod u_bit_mod (
        .i_byte (io_bus.ram_rd_data),
        .i_idx  (r_req.idx),
        .i_op   (r_req.op),
        .i_bit  (r_req.bitv),
        .o_byte (w_new),
        .o_old  (w_old)
    );

    always_comb begin
        w_read   = r_state == S_READ;
        w_write  = r_state == S_WRITE;
        w_modify = r_state == S_MODIFY;
        w_wr     = w_write || (w_modify && is_rmw_op(r_req.op));
    end

    assign io_bus.req_ready   = r_state == S_IDLE && !rst;
    assign io_bus.ram_rd_en   = w_read;
    assign io_bus.ram_rd_addr = w_read ? r_req.addr : 8'd0;
    assign io_bus.ram_wr      = w_wr;
    assign io_bus.ram_wr_en   = w_wr;
    assign io_bus.ram_wr_addr = w_wr ? r_req.addr : 8'd0;
    assign io_bus.ram_wr_data = w_write ? r_req.data : w_wr ? w_new : 8'd0;
    assign io_bus.rsp_valid   = w_write || w_modify;
    assign io_bus.rsp_data    = w_write ? r_req.data : w_modify ? w_new : 8'd0;
    assign io_bus.rsp_bit     = w_modify && is_bit_op(r_req.op) && !is_byte_rd(r_req.op) ? w_old : 1'b0;
endmodule

// File: tb/tb_oc8051_ram_rmw_ctrl.sv
// tb_oc8051_ram_rmw_ctrl: directed checks of byte, bit RMW, back-to-back and reset behaviour
module tb_oc8051_ram_rmw_ctrl;
    import oc8051_ram_rmw_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [7:0] mem [256];

    oc8051_ram_rmw_ctrl_if bus ();

    oc8051_ram_rmw_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wr) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    task automatic chk(input string tag, input string f, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%02h expected=%02h", tag, f, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] addr,
                         input logic [7:0] data, input logic b);
        @(negedge clk);
        chk(tag, "ready_before", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_bit   = b;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic rmw(input string tag, input logic [2:0] op, input logic [7:0] addr, input logic b,
                       input logic [7:0] e_addr, input logic [7:0] e_data, input logic e_bit, input logic e_wr);
        issue(tag, op, addr, 8'h00, b);
        @(negedge clk);
        chk(tag, "rd_en", bus.ram_rd_en, 1);
        chk(tag, "rd_addr", bus.ram_rd_addr, e_addr);
        chk(tag, "rsp_early", bus.rsp_valid, 0);
        chk(tag, "ready_busy", bus.req_ready, 0);
        @(negedge clk);
        chk(tag, "rsp_valid", bus.rsp_valid, 1);
        chk(tag, "rsp_data", bus.rsp_data, e_data);
        chk(tag, "rsp_bit", bus.rsp_bit, e_bit);
        chk(tag, "ram_wr", bus.ram_wr, e_wr);
        chk(tag, "ram_wr_en", bus.ram_wr_en, e_wr);
        chk(tag, "wr_addr", bus.ram_wr_addr, e_wr ? e_addr : 8'h00);
        chk(tag, "wr_data", bus.ram_wr_data, e_wr ? e_data : 8'h00);
        chk(tag, "rd_en_off", bus.ram_rd_en, 0);
        @(posedge clk);
        #1 chk(tag, "mem", mem[e_addr], e_data);
    endtask

    initial begin
        int nacc;
        int nrsp;
        logic prev;
        logic t;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[8'h2F] = 8'h80;
        bus.ram_rd_data = 8'h00;
        bus.req_valid = 1'b1;
        bus.req_op = OP_WR;
        bus.req_addr = 8'h55;
        bus.req_data = 8'h11;
        bus.req_bit = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset", "rsp_valid", bus.rsp_valid, 0);
        chk("reset", "ram_wr", bus.ram_wr, 0);
        chk("reset", "rd_en", bus.ram_rd_en, 0);
        chk("reset", "ready", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1 chk("reset", "ready_after", bus.req_ready, 1);

        issue("wr24", OP_WR, 8'h24, 8'hA5, 1'b0);
        @(negedge clk);
        chk("wr24", "ram_wr", bus.ram_wr, 1);
        chk("wr24", "ram_wr_en", bus.ram_wr_en, 1);
        chk("wr24", "wr_addr", bus.ram_wr_addr, 8'h24);
        chk("wr24", "wr_data", bus.ram_wr_data, 8'hA5);
        chk("wr24", "rsp_valid", bus.rsp_valid, 1);
        chk("wr24", "rsp_data", bus.rsp_data, 8'hA5);
        chk("wr24", "rsp_bit", bus.rsp_bit, 0);
        chk("wr24", "ready_busy", bus.req_ready, 0);
        chk("wr24", "rd_en", bus.ram_rd_en, 0);
        @(negedge clk);
        chk("wr24", "rsp_done", bus.rsp_valid, 0);
        chk("wr24", "wr_done", bus.ram_wr, 0);
        chk("wr24", "mem", mem[8'h24], 8'hA5);

        rmw("rd24",   OP_RD,   8'h24, 1'b0, 8'h24, 8'hA5, 1'b0, 1'b0);
        rmw("bset21", OP_BSET, 8'h21, 1'b0, 8'h24, 8'hA7, 1'b0, 1'b1);
        rmw("bclr27", OP_BCLR, 8'h27, 1'b0, 8'h24, 8'h27, 1'b1, 1'b1);
        rmw("bcpl20", OP_BCPL, 8'h20, 1'b0, 8'h24, 8'h26, 1'b1, 1'b1);
        rmw("bmov26", OP_BMOV, 8'h26, 1'b0, 8'h24, 8'h26, 1'b0, 1'b1);
        rmw("brd7f",  OP_BRD,  8'h7F, 1'b0, 8'h2F, 8'h80, 1'b1, 1'b0);
        rmw("brda1",  OP_BRD,  8'hA1, 1'b0, 8'h24, 8'h26, 1'b1, 1'b0);
        rmw("bmov7e", OP_BMOV, 8'h7E, 1'b1, 8'h2F, 8'hC0, 1'b0, 1'b1);
        rmw("rsv24",  3'd7,    8'h24, 1'b0, 8'h24, 8'h26, 1'b0, 1'b0);
        rmw("rd2f",   OP_RD,   8'h2F, 1'b0, 8'h2F, 8'hC0, 1'b0, 1'b0);

        nacc = 0;
        nrsp = 0;
        t = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = OP_WR;
        bus.req_addr = 8'h40;
        bus.req_data = 8'h00;
        prev = bus.req_ready;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prev) begin
                nacc++;
                chk("b2b", "ready_after_acc", bus.req_ready, 0);
            end
            if (bus.rsp_valid) nrsp++;
            chk("b2b", "overlap", {7'd0, bus.ram_rd_en & bus.ram_wr}, 8'h00);
            if (bus.req_ready) begin
                t = ~t;
                bus.req_op = t ? OP_RD : OP_WR;
                bus.req_data = 8'(i);
            end
            prev = bus.req_ready;
        end
        bus.req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
        end
        chk("b2b", "rsp_per_acc", 8'(nrsp), 8'(nacc));
        chk("b2b", "acc_count", 8'(nacc), 8'd8);

        issue("rst_bset", OP_BSET, 8'h20, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_bset", "in_read", bus.ram_rd_en, 1);
        rst = 1'b1;
        #1;
        chk("rst_bset", "rd_en", bus.ram_rd_en, 0);
        chk("rst_bset", "rd_addr", bus.ram_rd_addr, 8'h00);
        chk("rst_bset", "rsp_valid", bus.rsp_valid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_bset", "ram_wr", bus.ram_wr, 0);
            chk("rst_bset", "rsp_data", bus.rsp_data, 8'h00);
        end
        rst = 1'b0;
        #1 chk("rst_bset", "ready", bus.req_ready, 1);
        @(negedge clk);
        chk("rst_bset", "rsp_after", bus.rsp_valid, 0);
        chk("rst_bset", "mem", mem[8'h24], 8'h26);
        rmw("rd_after_rst", OP_RD, 8'h24, 1'b0, 8'h24, 8'h26, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
